filtro_fir_top: RTL and testbench
=================================

// Module: filtro_fir_top
// PURPOSE
//  Transmit pulse shaper: 1-bit symbol stream in, upsampled by 4, filtered by a 24-tap raised-cosine FIR.
//  The FIR is a polyphase structure: 4 phases x 6 taps; output is 8-bit signed, one sample per clock.
//  The internal symbol strobe also paces the upstream bit source through o_valid.
//  Sits between the bit source and the DAC/channel model.
// PARAMETERS
//  NB_COUNT   2  strobe counter width; OSR = 2**NB_COUNT; only 2 is legal (elaboration error otherwise)
//  NB_OUTPUT  8  o_data width, S(8,7) integer scale
//  N_TAPS_PH  6  taps per polyphase branch
// PORTS
//  clock     in   1  single system clock, rising edge
//  i_reset   in   1  asynchronous, active-high reset
//  i_enable  in   1  1 = run; 0 = freeze every register (state and o_data held)
//  i_data    in   1  current symbol bit; 1 -> +1, 0 -> -1; sampled when o_valid=1
//  o_valid   out  1  symbol strobe: 1-cycle pulse every OSR enabled clocks; source advances on it
//  o_data    out  8  signed filtered sample, registered
// BEHAVIOUR
//  - Reset (async): strobe cnt=0, o_valid=0, symbol shift reg sr[0..5]=0 (all -1), phase=0, o_data=0.
//  - Strobe: cnt increments each enabled clock, wraps mod OSR; o_valid = (cnt==OSR-1), combinational from cnt.
//    First pulse on the 4th enabled clock after reset release, then every 4 clocks.
//  - Per enabled clock with o_valid=1: sr <= {i_data, sr[0..4]} (sr[0] newest); phase <= 0.
//  - Per enabled clock with o_valid=0: phase <= phase+1 (mod 4); sr unchanged.
//  - Coefficients h[0..23] (S(8,7) ints) = 0,1,2,3,0,-7,-15,-16,0,34,77,114,
//    127,114,77,34,0,-16,-15,-7,0,3,2,1 (raised cosine, beta=0.5, 4 sps, centre at h[12]).
//  - Each enabled clock: o_data <= SAT8( sum_{k=0..5} h[4k+phase] * x(sr[k]) ), x = +/-1.
//    The sum is formed at full precision (>= 11-bit signed). Latency is 1 clock from sr/phase to o_data.
//  - SAT8 clamps to [-128,127].
//  - i_enable=0: no counter, phase, sr or o_data update; o_valid still reflects the frozen cnt.
//  - Reset mid-stream: immediate return to reset state; the stream restarts from phase 0 with an empty history.
// CONFIGURATION
//  FIR_SATURATION_EN defined: output clamped as above.
//  FIR_SATURATION_EN undefined: o_data = low 8 bits of the sum (two's-complement wrap).
// STRUCTURE
//  - Package fir_pkg holds:
//    - OSR, N_TAPS_PH, NB_COEFF=8, NB_ACC=11.
//    - The localparam coefficient array h[0:23].
//    - The saturate function.
//  - One sub-module, fir_symbol_strobe (NB_COUNT counter -> o_valid). It is instantiated in the top; its o_valid drives the FIR shift and phase reset.
//  - The polyphase MAC, shift register and phase counter live in the top.
// TESTING
//  1. Reset: i_reset=1 with clock running -> o_valid=0, o_data=0. Then release with i_enable=1.
//     Required: o_valid pulses on clocks 4, 8, 12, ...; never on two consecutive clocks.
//  2. i_data=0 held, after reset (sr all -1) -> o_data sequence per phase 0..3 = -127,-128,-128,-128, repeating.
//  3. i_data=1 held for >=6 symbols -> steady sequence 127,127,127,127. With FIR_SATURATION_EN undefined: 127,-127,-128,-127.
//  4. i_enable=0 for 10 clocks mid-stream -> o_data, o_valid, phase frozen. On resume, the sequence continues exactly where it stopped.
//  5. Alternating bits 1,0,1,0 -> after 6 symbols the output is periodic with 8 samples.
//     Phase-0 samples alternate in sign with magnitude 127. Compare against a bit-exact reference model using h[] above.
//  6. i_reset asserted for one clock mid-symbol -> o_data=0 and cnt=0 immediately. The next o_valid comes 4 clocks after release.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants for the transmit pulse shaper: oversampling ratio, widths,
// raised-cosine coefficients (beta=0.5, 4 sps) and the output clamp.
package fir_pkg;

   localparam int OSR       = 4;
   localparam int N_TAPS_PH = 6;
   localparam int N_TAPS    = OSR * N_TAPS_PH;
   localparam int NB_COEFF  = 8;
   localparam int NB_ACC    = 11;
   localparam int NB_OUT    = 8;
   localparam int NB_IDX    = $clog2(N_TAPS);

   // S(8,7) taps, centre at index 12; tap 4k+p belongs to polyphase branch p
   localparam logic signed [NB_COEFF-1:0] H [N_TAPS] = '{
      8'sd0,   8'sd1,   8'sd2,    8'sd3,    8'sd0,   -8'sd7,   -8'sd15, -8'sd16,
      8'sd0,   8'sd34,  8'sd77,   8'sd114,  8'sd127,  8'sd114,  8'sd77,  8'sd34,
      8'sd0,  -8'sd16, -8'sd15,  -8'sd7,    8'sd0,    8'sd3,    8'sd2,   8'sd1
   };

   localparam logic signed [NB_OUT-1:0] OUT_MAX = {1'b0, {(NB_OUT-1){1'b1}}};
   localparam logic signed [NB_OUT-1:0] OUT_MIN = {1'b1, {(NB_OUT-1){1'b0}}};

   function automatic logic signed [NB_OUT-1:0] saturate(
      input logic signed [NB_ACC-1:0] acc
   );
      if (acc > NB_ACC'(OUT_MAX))
         return OUT_MAX;
      else if (acc < NB_ACC'(OUT_MIN))
         return OUT_MIN;
      else
         return acc[NB_OUT-1:0];
   endfunction

endpackage

// File: rtl/filtro_fir_if.sv
// Symbol-source / sample-sink bundle of the pulse shaper.
// slave: the shaper side; master: the bit source / sample consumer side.
interface filtro_fir_if
   import fir_pkg::*;
#(
   parameter int NB_OUTPUT = NB_OUT
);
   logic                        i_enable;
   logic                        i_data;
   logic                        o_valid;
   logic signed [NB_OUTPUT-1:0] o_data;

   modport slave (
      input  i_enable,
      input  i_data,
      output o_valid,
      output o_data
   );

   modport master (
      output i_enable,
      output i_data,
      input  o_valid,
      input  o_data
   );
endinterface

// File: rtl/fir_symbol_strobe.sv
// Symbol strobe: free-running modulo-OSR counter, o_valid high while it sits
// on its last count so the source and the shift register advance together.
module fir_symbol_strobe
   import fir_pkg::*;
#(
   parameter int NB_COUNT = 2
) (
   input  logic clock,
   input  logic i_reset,
   input  logic i_enable,
   output logic o_valid
);

   if ((1 << NB_COUNT) != OSR) begin : g_bad_nb_count
      $error("fir_symbol_strobe: NB_COUNT must give 2**NB_COUNT == OSR");
   end

   logic [NB_COUNT-1:0] cnt;

   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset)
         cnt <= '0;
      else if (i_enable)
         cnt <= cnt + NB_COUNT'(1);
   end

   assign o_valid = (cnt == {NB_COUNT{1'b1}});

endmodule

// File: rtl/filtro_fir_top.sv
// Polyphase 24-tap raised-cosine pulse shaper, 1-bit symbols upsampled by 4.
// Build option FIR_SATURATION_EN: clamp o_data; otherwise keep the low 8 bits.
module filtro_fir_top
   import fir_pkg::*;
#(
   parameter int NB_COUNT  = 2,
   parameter int NB_OUTPUT = 8,
   parameter int N_TAPS_PH = 6
) (
   input  logic        clock,
   input  logic        i_reset,
   filtro_fir_if.slave bus
);

   if (NB_COUNT != 2) begin : g_bad_nb_count
      $error("filtro_fir_top: only NB_COUNT = 2 is supported");
   end
   if (NB_OUTPUT != NB_OUT) begin : g_bad_nb_output
      $error("filtro_fir_top: NB_OUTPUT must match the package output width");
   end
   if (N_TAPS_PH != fir_pkg::N_TAPS_PH) begin : g_bad_taps
      $error("filtro_fir_top: N_TAPS_PH must match the coefficient table");
   end

   logic                        strobe;
   logic [N_TAPS_PH-1:0]        sr_p0;
   logic [NB_COUNT-1:0]         phase_p0;
   logic signed [NB_ACC-1:0]    acc_p0;
   logic signed [NB_OUTPUT-1:0] out_p0;
   logic signed [NB_OUTPUT-1:0] data_p1;

   fir_symbol_strobe #(
      .NB_COUNT (NB_COUNT)
   ) u_strobe (
      .clock    (clock),
      .i_reset  (i_reset),
      .i_enable (bus.i_enable),
      .o_valid  (strobe)
   );

   // Stage p0: symbol history (sr_p0[0] newest, 0 encodes -1) and branch select
   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         sr_p0    <= '0;
         phase_p0 <= '0;
      end else if (bus.i_enable) begin
         if (strobe) begin
            sr_p0    <= {sr_p0[N_TAPS_PH-2:0], bus.i_data};
            phase_p0 <= '0;
         end else begin
            phase_p0 <= phase_p0 + NB_COUNT'(1);
         end
      end
   end

   // Symbols are +/-1, so each tap is an add or subtract of the coefficient
   always_comb begin
      logic [NB_IDX-1:0]          idx;
      logic signed [NB_COEFF-1:0] coef;
      acc_p0 = '0;
      idx    = '0;
      coef   = '0;
      for (int k = 0; k < N_TAPS_PH; k++) begin
         idx  = NB_IDX'(OSR * k) + NB_IDX'(phase_p0);
         coef = H[idx];
         if (sr_p0[k])
            acc_p0 = acc_p0 + NB_ACC'(coef);
         else
            acc_p0 = acc_p0 - NB_ACC'(coef);
      end
   end

`ifdef FIR_SATURATION_EN
   assign out_p0 = saturate(acc_p0);
`else
   assign out_p0 = acc_p0[NB_OUTPUT-1:0];
`endif

   // Stage p1: registered output sample
   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset)
         data_p1 <= '0;
      else if (bus.i_enable)
         data_p1 <= out_p0;
   end

   assign bus.o_valid = strobe;
   assign bus.o_data  = data_p1;

endmodule

// File: tb/tb_filtro_fir_top.sv
// Directed bench for filtro_fir_top: hand tables per phase plus a zero-stuffed
// convolution reference that follows every clock.
module tb_filtro_fir_top;

   logic clock = 1'b0;
   logic i_reset;

   filtro_fir_if #(.NB_OUTPUT(8)) bus ();

   filtro_fir_top dut (
      .clock   (clock),
      .i_reset (i_reset),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   int hc [24] = '{0, 1, 2, 3, 0, -7, -15, -16, 0, 34, 77, 114,
                   127, 114, 77, 34, 0, -16, -15, -7, 0, 3, 2, 1};

`ifdef FIR_SATURATION_EN
   int t2 [4] = '{-127, -128, -128, -128};
   int t3 [4] = '{127, 127, 127, 127};
`else
   int t2 [4] = '{-127, 127, -128, 127};
   int t3 [4] = '{127, -127, -128, -127};
`endif
   int t5 [4] = '{-127, -91, 0, 91};

   // reference: upsampled (zero-stuffed) symbol line convolved with hc
   int m_k;
   int m_sym;
   int m_y;
   int m_dl [24];

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int out_conv(input int s);
`ifdef FIR_SATURATION_EN
      return (s > 127) ? 127 : ((s < -128) ? -128 : s);
`else
      logic signed [7:0] b;
      b = s[7:0];
      return int'(b);
`endif
   endfunction

   function automatic void model_reset();
      m_k   = 0;
      m_sym = -1;
      m_y   = 0;
      for (int j = 0; j < 24; j++)
         m_dl[j] = (j % 4 == 3) ? -1 : 0;
   endfunction

   function automatic void model_step(input bit din);
      int s;
      m_k++;
      for (int j = 23; j > 0; j--)
         m_dl[j] = m_dl[j-1];
      m_dl[0] = ((m_k - 1) % 4 == 0) ? m_sym : 0;
      s = 0;
      for (int j = 0; j < 24; j++)
         s += hc[j] * m_dl[j];
      m_y = out_conv(s);
      if (m_k % 4 == 0)
         m_sym = din ? 1 : -1;
   endfunction

   task automatic step(input string tag, input bit en, input bit din);
      bus.i_enable = en;
      bus.i_data   = din;
      @(posedge clock);
      if (en)
         model_step(din);
      #1;
      chk({tag, "_vld"}, int'(bus.o_valid), (m_k % 4 == 3) ? 1 : 0);
      chk({tag, "_dat"}, int'($signed(bus.o_data)), m_y);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int prev_v;
      bit alt;
      int last;

      i_reset      = 1'b1;
      bus.i_enable = 1'b0;
      bus.i_data   = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_vld", int'(bus.o_valid), 0);
      chk("rst_dat", int'($signed(bus.o_data)), 0);
      model_reset();
      i_reset = 1'b0;

      // strobe timing and all -1 history
      prev_v = 0;
      for (int n = 1; n <= 12; n++) begin
         step("t1", 1'b1, 1'b0);
         chk("t1_strobe", int'(bus.o_valid), (n % 4 == 3) ? 1 : 0);
         chk("t1_no_consec", prev_v & int'(bus.o_valid), 0);
         chk("t2_neg", int'($signed(bus.o_data)), t2[(n - 1) % 4]);
         prev_v = int'(bus.o_valid);
      end

      // all +1 history after six ones
      for (int n = 13; n <= 44; n++) begin
         step("t3", 1'b1, 1'b1);
         if (n >= 37)
            chk("t3_pos", int'($signed(bus.o_data)), t3[(n - 1) % 4]);
      end

      // freeze with the strobe high, then resume
      for (int n = 45; n <= 47; n++)
         step("t4_pre", 1'b1, 1'b1);
      for (int n = 0; n < 10; n++) begin
         step("t4_frz", 1'b0, 1'b0);
         chk("t4_hold_dat", int'($signed(bus.o_data)), t3[2]);
         chk("t4_hold_vld", int'(bus.o_valid), 1);
      end
      for (int n = 0; n < 8; n++) begin
         step("t4_res", 1'b1, 1'b1);
         chk("t4_resume", int'($signed(bus.o_data)), t3[(m_k - 1) % 4]);
      end

      // reset mid-symbol while the strobe is high
      while (m_k % 4 != 3)
         step("t6_pre", 1'b1, 1'b1);
      i_reset = 1'b1;
      #1;
      chk("t6_rst_dat", int'($signed(bus.o_data)), 0);
      chk("t6_rst_vld", int'(bus.o_valid), 0);
      model_reset();
      @(posedge clock);
      #1;
      i_reset = 1'b0;

      // alternating symbols from an empty history
      alt  = 1'b1;
      last = -1;
      for (int n = 1; n <= 64; n++) begin
         step("t5", 1'b1, alt);
         if (n <= 4)
            chk("t6_strobe", int'(bus.o_valid), (n == 3) ? 1 : 0);
         if (n >= 25)
            chk("t5_alt", int'($signed(bus.o_data)), t5[(n - 1) % 4] * last);
         if (n % 4 == 0) begin
            last = alt ? 1 : -1;
            alt  = ~alt;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
